// File: rtl/frame_loader_if.sv
// Stream-in and port-A write bundle for frame_loader.
// master: byte source / RAM side observer; slave: the loader itself.
interface frame_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              start_frame;
  logic [7:0]        data_in;
  logic              data_valid;
  logic              data_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_abort;

  modport master (
    output start_frame, data_in, data_valid,
    input  data_ready, wr_en, wr_addr, wr_data, busy, frame_done, frame_abort
  );

  modport slave (
    input  start_frame, data_in, data_valid,
    output data_ready, wr_en, wr_addr, wr_data, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/frame_loader.sv
// Loads one row-major byte stream into framebuffer port A with subpanel/colour/row/column packing.
// Optional idle-timeout abort enabled by defining FRAME_LOADER_TIMEOUT_EN.
module frame_loader #(
  parameter int unsigned PIXEL_WIDTH      = 64,
  parameter int unsigned PIXEL_HEIGHT     = 32,
  parameter int unsigned PIXEL_HALFHEIGHT = 16,
  parameter int unsigned BYTES_PER_PIXEL  = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input logic          clk,
  input logic          reset,
  frame_loader_if.slave bus
);

  localparam int unsigned NUM_SUB = PIXEL_HEIGHT / PIXEL_HALFHEIGHT;
  localparam int unsigned SP_W    = $clog2(NUM_SUB);
  localparam int unsigned BI_W    = $clog2(BYTES_PER_PIXEL);
  localparam int unsigned RL_W    = $clog2(PIXEL_HALFHEIGHT);
  localparam int unsigned COL_W   = $clog2(PIXEL_WIDTH);
  localparam int unsigned ADDR_W  = SP_W + BI_W + RL_W + COL_W;
  // Zero-width fields still need a 1-bit counter; it simply never leaves 0
  localparam int unsigned SP_CW   = (SP_W  == 0) ? 1 : SP_W;
  localparam int unsigned BI_CW   = (BI_W  == 0) ? 1 : BI_W;
  localparam int unsigned RL_CW   = (RL_W  == 0) ? 1 : RL_W;
  localparam int unsigned COL_CW  = (COL_W == 0) ? 1 : COL_W;

  if ((PIXEL_HEIGHT % PIXEL_HALFHEIGHT) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("frame_loader: invalid parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state,   w_state_nxt;
  logic [SP_CW-1:0]    r_sp,      w_sp_nxt;
  logic [BI_CW-1:0]    r_bi,      w_bi_nxt;
  logic [RL_CW-1:0]    r_rl,      w_rl_nxt;
  logic [COL_CW-1:0]   r_col,     w_col_nxt;
  logic                r_ready,   w_ready_nxt;
  logic                r_wr_en,   w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [7:0]          r_wr_data, w_wr_data_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                w_accept;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr;

`ifdef FRAME_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]     r_idle,    w_idle_nxt;
  logic                r_abort,   w_abort_nxt;
`endif

  assign w_accept = bus.data_valid & r_ready;
  assign w_last   = (r_bi  == BI_CW'(BYTES_PER_PIXEL - 1))
                  & (r_col == COL_CW'(PIXEL_WIDTH - 1))
                  & (r_rl  == RL_CW'(PIXEL_HALFHEIGHT - 1))
                  & (r_sp  == SP_CW'(NUM_SUB - 1));
  assign w_addr   = (ADDR_W'(r_sp) << (BI_W + RL_W + COL_W))
                  | (ADDR_W'(r_bi) << (RL_W + COL_W))
                  | (ADDR_W'(r_rl) << COL_W)
                  |  ADDR_W'(r_col);

  // Next-state, counter advance and registered-output values
  always_comb begin
    w_state_nxt   = r_state;
    w_sp_nxt      = r_sp;
    w_bi_nxt      = r_bi;
    w_rl_nxt      = r_rl;
    w_col_nxt     = r_col;
    w_ready_nxt   = r_ready;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
`ifdef FRAME_LOADER_TIMEOUT_EN
    w_idle_nxt    = r_idle;
    w_abort_nxt   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_frame) begin
          w_state_nxt = S_LOAD;
          w_sp_nxt    = '0;
          w_bi_nxt    = '0;
          w_rl_nxt    = '0;
          w_col_nxt   = '0;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
`ifdef FRAME_LOADER_TIMEOUT_EN
          w_idle_nxt  = '0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.start_frame) begin
          // Restart: a byte accepted in this same cycle is dropped
          w_sp_nxt  = '0;
          w_bi_nxt  = '0;
          w_rl_nxt  = '0;
          w_col_nxt = '0;
`ifdef FRAME_LOADER_TIMEOUT_EN
          w_idle_nxt = '0;
`endif
        end else if (w_accept) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_addr;
          w_wr_data_nxt = bus.data_in;
`ifdef FRAME_LOADER_TIMEOUT_EN
          w_idle_nxt    = '0;
`endif
          if (r_bi == BI_CW'(BYTES_PER_PIXEL - 1)) begin
            w_bi_nxt = '0;
            if (r_col == COL_CW'(PIXEL_WIDTH - 1)) begin
              w_col_nxt = '0;
              if (r_rl == RL_CW'(PIXEL_HALFHEIGHT - 1)) begin
                w_rl_nxt = '0;
                w_sp_nxt = r_sp + SP_CW'(1);
              end else begin
                w_rl_nxt = r_rl + RL_CW'(1);
              end
            end else begin
              w_col_nxt = r_col + COL_CW'(1);
            end
          end else begin
            w_bi_nxt = r_bi + BI_CW'(1);
          end
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_ready_nxt = 1'b0;
          end
        end else begin
`ifdef FRAME_LOADER_TIMEOUT_EN
          if (r_idle == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_abort_nxt = 1'b1;
            w_idle_nxt  = '0;
            w_sp_nxt    = '0;
            w_bi_nxt    = '0;
            w_rl_nxt    = '0;
            w_col_nxt   = '0;
          end else begin
            w_idle_nxt = r_idle + TO_W'(1);
          end
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sp      <= '0;
      r_bi      <= '0;
      r_rl      <= '0;
      r_col     <= '0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef FRAME_LOADER_TIMEOUT_EN
      r_idle    <= '0;
      r_abort   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_sp      <= w_sp_nxt;
      r_bi      <= w_bi_nxt;
      r_rl      <= w_rl_nxt;
      r_col     <= w_col_nxt;
      r_ready   <= w_ready_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
`ifdef FRAME_LOADER_TIMEOUT_EN
      r_idle    <= w_idle_nxt;
      r_abort   <= w_abort_nxt;
`endif
    end
  end

  assign bus.data_ready = r_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
`ifdef FRAME_LOADER_TIMEOUT_EN
  assign bus.frame_abort = r_abort;
`else
  assign bus.frame_abort = 1'b0;
`endif

endmodule
